uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Downstream consumer of the PDU byte FIFO; drains queued bytes onto the host UART line as 8N1 frames.
- Frame format: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.
- Watches the queue's empty flag, latches the head byte, pulses dequeue once per byte, then serializes.
- Sits between the PDU output queue and the board `tx` pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- DATA_BITS, 8, payload bits per frame. Fixed at 8 to match the queue width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable. Low acts as a synchronous reset, same as rst.
- queue_empty  input  1  FIFO empty flag.
- queue_head_data  input  8  byte at the FIFO head. Valid whenever queue_empty=0.
- dequeue  output  1  registered, one-cycle pulse; pops the FIFO head.
- tx  output  1  registered serial line; idles high.
- busy  output  1  registered; high from START entry through the last STOP cycle.

Behaviour:
- Reset (rst | ~en sampled at posedge):
  - Next state is IDLE.
  - tx=1, dequeue=0, busy=0.
  - Bit counter, baud counter and shift register all clear to 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If queue_empty=0 at a posedge: shift_reg <= queue_head_data, dequeue <= 1, busy <= 1, tx <= 0, state <= START, baud_cnt <= 0.
  - Otherwise stay in IDLE.
- dequeue:
  - High for exactly one cycle: the first START cycle.
  - Never asserted in any other state, so the FIFO's stale empty flag during that cycle cannot cause a double pop.
  - The FIFO head advances at the posedge ending that cycle.
- baud_cnt:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 within each bit period.
  - The bit-period boundary is baud_cnt == CLKS_PER_BIT-1. At that point baud_cnt wraps to 0.
- START: tx=0 for CLKS_PER_BIT cycles. At the boundary: tx <= shift_reg[0], bit_cnt <= 0, state <= DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At each boundary, shift right; bit_cnt increments, width 3.
  - After bit 7's period: tx <= 1, state <= STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the boundary: busy <= 0, state <= IDLE.
- Timing:
  - Frame is exactly 10*CLKS_PER_BIT cycles of tx activity.
  - Back-to-back bytes have a 1-cycle IDLE gap, so the frame period is 10*CLKS_PER_BIT+1 cycles.
  - Latency from queue_empty falling to the tx falling edge: 1 cycle.
- Boundary conditions:
  - Empty queue: stay in IDLE indefinitely with tx=1 and no dequeue.
  - Queue refilled during a frame: ignored until IDLE.
  - rst or en low mid-frame: tx returns to 1 at the next posedge and the frame is aborted. The already-dequeued byte is discarded and not retransmitted.
  - queue_head_data changing mid-frame: no effect; only shift_reg is used after the latch.
- No combinational path from any input to any output.

Decomposition:
- Package pdu_uart_pkg:
  - state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - DEFAULT_CLKS_PER_BIT=868;
  - UART_DATA_BITS=8.
  - The matching UART receiver will share this package.
- One natural sub-module, uart_baud_counter:
  - parameterized by CLKS_PER_BIT;
  - inputs clear and run; output a one-cycle tick at the bit boundary.
  - The receiver will reuse it.

Test Plan:
- Reset: hold rst 3 cycles with queue_empty=0 → tx=1, dequeue=0, busy=0 throughout; first dequeue occurs 1 cycle after rst drops.
- Single byte, CLKS_PER_BIT=4, head=0xA5:
  - tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1;
  - dequeue high exactly 1 cycle, coincident with the first start-bit cycle;
  - busy high 40 cycles.
- Back-to-back: model FIFO holding 0x00, 0xFF, 0x3C, CLKS_PER_BIT=4 → three dequeue pulses spaced 41 cycles apart; decoded bytes match in order; tx=1 in each gap cycle.
- Empty queue: queue_empty=1 for 200 cycles → tx constantly 1, no dequeue pulse, busy=0.
- Mid-frame reset: assert rst during data bit 3 of 0x55 → tx=1 on the next cycle, busy=0, state IDLE; after release with queue non-empty, the next byte is sent in full and 0x55 is not resent.
- en low during STOP for 2 cycles → identical to rst: tx=1, no further dequeue until en returns; transmission then resumes from IDLE.

Source files
------------

// File: rtl/pdu_uart_pkg.sv
// Shared definitions for the PDU UART transmitter and its future receiver twin.
// State encoding and default bit timing live here so both sides stay in step.
package pdu_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and flags the last cycle.
// o_tick is high during the final cycle of each bit period, when the count wraps.
import pdu_uart_pkg::*;

module uart_baud_counter #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Drains the PDU byte queue onto the UART line as 8N1 frames, one dequeue per byte.
// All outputs are registered; the head byte is captured once and never re-read mid-frame.
import pdu_uart_pkg::*;

module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 queue_empty,
    input  logic [DATA_BITS-1:0] queue_head_data,
    output logic                 dequeue,
    output logic                 tx,
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_dequeue;
    logic                 r_tx;
    logic                 r_busy;
    logic                 w_srst;
    logic                 w_tick;

    assign w_srst  = rst | ~en;
    assign dequeue = r_dequeue;
    assign tx      = r_tx;
    assign busy    = r_busy;

    // The timer sits at zero through IDLE so START always begins a fresh bit period.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .i_clear(w_srst | (r_state == ST_IDLE)),
        .i_run  (r_state != ST_IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (w_srst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_dequeue <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_dequeue <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!queue_empty) begin
                        r_shift   <= queue_head_data;
                        r_dequeue <= 1'b1;
                        r_busy    <= 1'b1;
                        r_tx      <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a cycle-level frame model plus directed frame captures.
// The model rebuilds each expected 8N1 waveform from the dequeued byte and checks tx/busy/dequeue every cycle.
module tb_uart_tx_serializer;

    localparam int N     = 4;
    localparam int FRAME = 10 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       queue_empty = 1'b1;
    logic [7:0] queue_head_data = 8'h00;
    logic       dequeue;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .CLKS_PER_BIT(N),
        .DATA_BITS   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .queue_empty    (queue_empty),
        .queue_head_data(queue_head_data),
        .dequeue        (dequeue),
        .tx             (tx),
        .busy           (busy)
    );

    int          total = 0;
    int          bad = 0;
    logic [7:0]  fifo[$];
    bit          wave[$];
    logic        rst_last = 1'b1;
    logic        idle_last = 1'b1;
    logic        empty_last = 1'b1;
    logic [7:0]  head_last = 8'h00;
    time         last_deq_time = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one frame = start, 8 data bits LSB-first, stop, each N cycles wide.
    always @(negedge clk) begin : model
        logic e_tx, e_busy, e_deq;
        bit   b;
        e_deq = 1'b0;
        if (rst_last) begin
            wave.delete();
        end else if (idle_last && !empty_last) begin
            e_deq = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (i == 0)      b = 1'b0;
                else if (i == 9) b = 1'b1;
                else             b = head_last[i-1];
                repeat (N) wave.push_back(b);
            end
            $display("tx frame byte=%02h t=%0t", head_last, $time);
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        if (wave.size() > 0) begin
            e_tx   = wave.pop_front();
            e_busy = 1'b1;
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
        end
        chk("model_tx", {31'd0, tx}, {31'd0, e_tx});
        chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
        chk("model_dequeue", {31'd0, dequeue}, {31'd0, e_deq});
        rst_last  = rst | ~en;
        idle_last = ~e_busy;
        queue_empty     = (fifo.size() == 0);
        queue_head_data = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
        empty_last = queue_empty;
        head_last  = queue_head_data;
    end

    task automatic wait_deq(output bit ok);
        int w = 0;
        while (dequeue !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        ok = (dequeue === 1'b1);
        chk("dequeue_wait", {31'd0, ok}, 32'd1);
        if (ok) last_deq_time = $time;
    endtask

    // Samples mid-bit values; returns at the negedge of the cycle right after the stop bit.
    task automatic capture_frame(output logic [9:0] bits, output int busy_cyc, output int deq_cyc);
        bit ok;
        bits = '0;
        busy_cyc = 0;
        deq_cyc = 0;
        wait_deq(ok);
        if (!ok) return;
        for (int c = 0; c <= FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (busy === 1'b1) busy_cyc++;
            if (dequeue === 1'b1) deq_cyc++;
            if ((c % N) == (N / 2) && (c / N) < 10) bits[c/N] = tx;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_bits;
        int         exp_busy;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [9:0] bits;
        int         bc, dc, w, cnt_deq, cnt_lo, cnt_busy;
        time        t[3];
        bit         ok;

        vecs[0] = '{8'hA5, 10'b1101001010, FRAME};
        vecs[1] = '{8'h00, 10'b1000000000, FRAME};
        vecs[2] = '{8'hFF, 10'b1111111110, FRAME};
        vecs[3] = '{8'h3C, 10'b1001111000, FRAME};
        vecs[4] = '{8'h81, 10'b1100000010, FRAME};

        // Reset held with a non-empty queue
        rst = 1'b1;
        fifo.push_back(8'h11);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_no_deq_yet", {31'd0, dequeue}, 32'd0);
        @(negedge clk);
        chk("rst_release_first_deq", {31'd0, dequeue}, 32'd1);
        capture_frame(bits, bc, dc);
        chk("rst_frame_bits", {22'd0, bits}, 32'h222);

        // Table-driven single frames
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2 fifo.push_back(vecs[i].data);
            capture_frame(bits, bc, dc);
            chk($sformatf("vec%0d_bits", i), {22'd0, bits}, {22'd0, vecs[i].exp_bits});
            chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_busy);
            chk($sformatf("vec%0d_dequeue_cycles", i), dc, 32'd1);
        end

        // Back-to-back frames
        @(posedge clk);
        #2;
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        fifo.push_back(8'h3C);
        for (int k = 0; k < 3; k++) begin
            capture_frame(bits, bc, dc);
            t[k] = last_deq_time;
            chk($sformatf("b2b%0d_bits", k), {22'd0, bits}, {22'd0, vecs[k+1].exp_bits});
            chk($sformatf("b2b%0d_gap_tx", k), {31'd0, tx}, 32'd1);
        end
        chk("b2b_spacing_01", 32'(t[1] - t[0]), 32'(41 * 10));
        chk("b2b_spacing_12", 32'(t[2] - t[1]), 32'(41 * 10));

        // Empty queue for 200 cycles
        cnt_deq = 0; cnt_lo = 0; cnt_busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (dequeue !== 1'b0) cnt_deq++;
            if (tx !== 1'b1) cnt_lo++;
            if (busy !== 1'b0) cnt_busy++;
        end
        chk("empty_dequeues", cnt_deq, 32'd0);
        chk("empty_tx_low", cnt_lo, 32'd0);
        chk("empty_busy", cnt_busy, 32'd0);

        // Reset during data bit 3 of 0x55; 0x99 follows and 0x55 is not resent
        @(posedge clk);
        #2;
        fifo.push_back(8'h55);
        fifo.push_back(8'h99);
        wait_deq(ok);
        repeat (4 * N + 1) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        capture_frame(bits, bc, dc);
        chk("midrst_next_bits", {22'd0, bits}, {22'd0, 10'b1100110010});
        cnt_deq = 0;
        repeat (60) begin
            @(negedge clk);
            if (dequeue === 1'b1) cnt_deq++;
        end
        chk("midrst_no_resend", cnt_deq, 32'd0);

        // en low for 2 cycles during STOP of 0x81; 0x42 resumes afterwards
        @(posedge clk);
        #2;
        fifo.push_back(8'h81);
        fifo.push_back(8'h42);
        wait_deq(ok);
        repeat (9 * N + 1) @(negedge clk);
        @(posedge clk);
        #2 en = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("en_low_tx", {31'd0, tx}, 32'd1);
        chk("en_low_busy", {31'd0, busy}, 32'd0);
        chk("en_low_dequeue", {31'd0, dequeue}, 32'd0);
        @(posedge clk);
        #2 en = 1'b1;
        capture_frame(bits, bc, dc);
        chk("en_resume_bits", {22'd0, bits}, {22'd0, 10'b1010000100});

        // Randomised traffic with occasional rst / en aborts
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 60)) @(posedge clk);
            @(posedge clk);
            #2;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) fifo.push_back(8'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) rst = 1'b1;
                else en = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2;
                rst = 1'b0;
                en = 1'b1;
            end
        end
        w = 0;
        while ((fifo.size() != 0 || busy !== 1'b0) && w < 8000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_done", {31'd0, (w < 8000)}, 32'd1);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
